// File: rtl/vga_crt_pkg.sv
// Shared CRT constants: row/blink counter widths and register bit positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_crt_pkg;
    localparam int ROW_W    = 5;
    localparam int BLINK_W  = 5;
    localparam int CR09_DBL = 7;
    localparam int CR0A_OFF = 5;
    // reg_cr09 carries only CR09[7] and CR09[4:0], so CR09[7] lands at input bit 5
    localparam int CR09_DBL_IN = CR09_DBL - 2;
endpackage

// File: rtl/vrow_scan_if.sv
// Strobe, register and qualifier bundle between the vertical CRT controller and vrow_scan.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are strobes or levels.
interface vrow_scan_if;
    import vga_crt_pkg::*;
    logic               txt_crt_line_end_pulse;
    logic               c_pre_vde;
    logic               c_split_screen_pulse;
    logic               c_vde;
    logic [4:0]         reg_cr08;
    logic [5:0]         reg_cr09;
    logic [5:0]         reg_cr0a;
    logic [4:0]         reg_cr0b;
    logic [4:0]         reg_cr14;
    logic [ROW_W-1:0]   row_scan;
    logic               row_end_pulse;
    logic               dbl_phase;
    logic               cursor_row_en;
    logic               underline_row;
    logic               cursor_blink;
    logic               char_blink;

    modport master (
        output txt_crt_line_end_pulse, c_pre_vde, c_split_screen_pulse, c_vde,
        output reg_cr08, reg_cr09, reg_cr0a, reg_cr0b, reg_cr14,
        input  row_scan, row_end_pulse, dbl_phase, cursor_row_en, underline_row,
        input  cursor_blink, char_blink
    );

    modport slave (
        input  txt_crt_line_end_pulse, c_pre_vde, c_split_screen_pulse, c_vde,
        input  reg_cr08, reg_cr09, reg_cr0a, reg_cr0b, reg_cr14,
        output row_scan, row_end_pulse, dbl_phase, cursor_row_en, underline_row,
        output cursor_blink, char_blink
    );
endinterface

// File: rtl/vrow_blink_cntr.sv
// Frame blink counter: advances once per frame start; cursor phase = bit 3, char phase = bit 4.
// Latency: outputs change the cycle after inc.
// Backpressure: none.
module vrow_blink_cntr
    import vga_crt_pkg::*;
(
    input  logic t_crt_clk,
    input  logic h_reset_n,
    input  logic inc,
    output logic cursor_blink,
    output logic char_blink
);
    logic [BLINK_W-1:0] cnt;

    always_ff @(posedge t_crt_clk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + {{(BLINK_W-1){1'b0}}, 1'b1};
        end
    end

    assign cursor_blink = cnt[3];
    assign char_blink   = cnt[4];
endmodule

// File: rtl/vrow_scan.sv
// Character-row scan counter with cursor/underline qualifiers; blink counter under VROW_BLINK_EN.
// Latency: row_scan/dbl_phase/row_end_pulse 1 cycle after strobe, qualifiers 2 cycles.
// Backpressure: none; strobes are consumed every cycle.
module vrow_scan
    import vga_crt_pkg::*;
(
    input  logic        t_crt_clk,
    input  logic        h_reset_n,
    vrow_scan_if.slave  bus
);
    logic [ROW_W-1:0] row_scan;
    logic             dbl_phase;
    logic             row_end_pulse;
    logic             cursor_row_en;
    logic             underline_row;
    logic             dbl_en;
    logic [ROW_W-1:0] max_scan;

    assign dbl_en   = bus.reg_cr09[CR09_DBL_IN];
    assign max_scan = bus.reg_cr09[ROW_W-1:0];

    // Frame start beats split screen, which beats the line advance
    always_ff @(posedge t_crt_clk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            row_scan      <= '0;
            dbl_phase     <= 1'b0;
            row_end_pulse <= 1'b0;
        end else if (bus.c_pre_vde) begin
            row_scan      <= bus.reg_cr08;
            dbl_phase     <= 1'b0;
            row_end_pulse <= 1'b0;
        end else if (bus.c_split_screen_pulse) begin
            row_scan      <= '0;
            dbl_phase     <= 1'b0;
            row_end_pulse <= 1'b0;
        end else if (bus.txt_crt_line_end_pulse && bus.c_vde) begin
            if (dbl_en && !dbl_phase) begin
                dbl_phase     <= 1'b1;
                row_end_pulse <= 1'b0;
            end else begin
                dbl_phase <= 1'b0;
                if (row_scan == max_scan) begin
                    row_scan      <= '0;
                    row_end_pulse <= 1'b1;
                end else begin
                    // Preset above max wraps through 31 -> 0 before matching
                    row_scan      <= row_scan + 5'd1;
                    row_end_pulse <= 1'b0;
                end
            end
        end else begin
            row_end_pulse <= 1'b0;
        end
    end

    always_ff @(posedge t_crt_clk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            cursor_row_en <= 1'b0;
            underline_row <= 1'b0;
        end else begin
            cursor_row_en <= !bus.reg_cr0a[CR0A_OFF]
                             && (bus.reg_cr0a[ROW_W-1:0] <= row_scan)
                             && (row_scan <= bus.reg_cr0b);
            underline_row <= (row_scan == bus.reg_cr14);
        end
    end

    assign bus.row_scan      = row_scan;
    assign bus.dbl_phase     = dbl_phase;
    assign bus.row_end_pulse = row_end_pulse;
    assign bus.cursor_row_en = cursor_row_en;
    assign bus.underline_row = underline_row;

`ifdef VROW_BLINK_EN
    vrow_blink_cntr u_blink (
        .t_crt_clk    (t_crt_clk),
        .h_reset_n    (h_reset_n),
        .inc          (bus.c_pre_vde),
        .cursor_blink (bus.cursor_blink),
        .char_blink   (bus.char_blink)
    );
`else
    assign bus.cursor_blink = 1'b1;
    assign bus.char_blink   = 1'b1;
`endif
endmodule

// File: tb/tb_vrow_scan.sv
// Directed bench for vrow_scan: presets, double scan, split screen, cursor band, blink, reset.
module tb_vrow_scan;
    logic t_crt_clk = 1'b0;
    logic h_reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    vrow_scan_if bus();

    vrow_scan u_dut (
        .t_crt_clk (t_crt_clk),
        .h_reset_n (h_reset_n),
        .bus       (bus.slave)
    );

    always #5 t_crt_clk = ~t_crt_clk;

`ifdef VROW_BLINK_EN
    localparam logic BLINK_RST = 1'b0;
`else
    localparam logic BLINK_RST = 1'b1;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(negedge t_crt_clk);
    endtask

    task automatic pre(input logic [4:0] preset);
        @(negedge t_crt_clk);
        bus.reg_cr08  = preset;
        bus.c_pre_vde = 1'b1;
        @(negedge t_crt_clk);
        bus.c_pre_vde = 1'b0;
    endtask

    task automatic line();
        @(negedge t_crt_clk);
        bus.txt_crt_line_end_pulse = 1'b1;
        @(negedge t_crt_clk);
        bus.txt_crt_line_end_pulse = 1'b0;
    endtask

    task automatic chk_row(input string tag, input logic [4:0] row, input logic dbl, input logic rep);
        chk({tag, ".row"}, {27'd0, bus.row_scan}, {27'd0, row});
        chk({tag, ".dbl"}, {31'd0, bus.dbl_phase}, {31'd0, dbl});
        chk({tag, ".rep"}, {31'd0, bus.row_end_pulse}, {31'd0, rep});
    endtask

    initial begin
        bus.txt_crt_line_end_pulse = 1'b0;
        bus.c_pre_vde              = 1'b0;
        bus.c_split_screen_pulse   = 1'b0;
        bus.c_vde                  = 1'b0;
        bus.reg_cr08               = 5'd0;
        bus.reg_cr09               = 6'h03;
        bus.reg_cr0a               = 6'h20;
        bus.reg_cr0b               = 5'd0;
        bus.reg_cr14               = 5'd31;

        #12;
        chk_row("reset", 5'd0, 1'b0, 1'b0);
        chk("reset.cur", {31'd0, bus.cursor_row_en}, 32'd0);
        chk("reset.ul", {31'd0, bus.underline_row}, 32'd0);
        chk("reset.cblink", {31'd0, bus.cursor_blink}, {31'd0, BLINK_RST});
        chk("reset.chblink", {31'd0, bus.char_blink}, {31'd0, BLINK_RST});
        h_reset_n = 1'b1;
        bus.c_vde = 1'b1;

        // Blink: frames 1..16
        for (int f = 1; f <= 16; f++) begin
            pre(5'd0);
`ifdef VROW_BLINK_EN
            if (f == 7)  chk("blink.f7.cur", {31'd0, bus.cursor_blink}, 32'd0);
            if (f == 8)  chk("blink.f8.cur", {31'd0, bus.cursor_blink}, 32'd1);
            if (f == 15) chk("blink.f15.chr", {31'd0, bus.char_blink}, 32'd0);
            if (f == 16) begin
                chk("blink.f16.chr", {31'd0, bus.char_blink}, 32'd1);
                chk("blink.f16.cur", {31'd0, bus.cursor_blink}, 32'd0);
            end
`else
            if (f == 8 || f == 16) begin
                chk("blink.fixed.cur", {31'd0, bus.cursor_blink}, 32'd1);
                chk("blink.fixed.chr", {31'd0, bus.char_blink}, 32'd1);
            end
`endif
        end

        // Preset and row end
        bus.reg_cr09 = 6'h03;
        pre(5'd2);  chk_row("pre2", 5'd2, 1'b0, 1'b0);
        line();     chk_row("ln1", 5'd3, 1'b0, 1'b0);
        line();     chk_row("ln2", 5'd0, 1'b0, 1'b1);
        line();     chk_row("ln3", 5'd1, 1'b0, 1'b0);
        pre(5'd0);  chk_row("pre0", 5'd0, 1'b0, 1'b0);

        // Double scan, max 1
        bus.reg_cr09 = 6'h21;
        line();     chk_row("dbl1", 5'd0, 1'b1, 1'b0);
        line();     chk_row("dbl2", 5'd1, 1'b0, 1'b0);
        line();     chk_row("dbl3", 5'd1, 1'b1, 1'b0);
        line();     chk_row("dbl4", 5'd0, 1'b0, 1'b1);
        idle();     chk("dbl.rep_width", {31'd0, bus.row_end_pulse}, 32'd0);

        // Line pulse ignored outside display, then split beats line pulse
        bus.reg_cr09 = 6'h1F;
        pre(5'd5);
        bus.c_vde = 1'b0;
        line();     chk_row("novde", 5'd5, 1'b0, 1'b0);
        bus.c_vde = 1'b1;
        @(negedge t_crt_clk);
        bus.c_split_screen_pulse   = 1'b1;
        bus.txt_crt_line_end_pulse = 1'b1;
        @(negedge t_crt_clk);
        bus.c_split_screen_pulse   = 1'b0;
        bus.txt_crt_line_end_pulse = 1'b0;
        chk_row("split", 5'd0, 1'b0, 1'b0);

        // Preset above max: 30, 31, 0, 1, 2 -> row end
        bus.reg_cr09 = 6'h02;
        pre(5'd30); chk_row("wrap30", 5'd30, 1'b0, 1'b0);
        line();     chk_row("wrap31", 5'd31, 1'b0, 1'b0);
        line();     chk_row("wrap0", 5'd0, 1'b0, 1'b0);
        line();
        line();     chk_row("wrap2", 5'd2, 1'b0, 1'b0);
        line();     chk_row("wrapend", 5'd0, 1'b0, 1'b1);

        // Cursor band 13..14, underline at 12
        bus.reg_cr09 = 6'h1F;
        bus.reg_cr0a = 6'h0D;
        bus.reg_cr0b = 5'd14;
        bus.reg_cr14 = 5'd12;
        pre(5'd11);
        for (int r = 11; r <= 16; r++) begin
            idle();
            chk("cur.band", {31'd0, bus.cursor_row_en}, {31'd0, (r == 13 || r == 14)});
            chk("ul.row", {31'd0, bus.underline_row}, {31'd0, (r == 12)});
            line();
        end
        bus.reg_cr0a = 6'h2D;
        pre(5'd13);
        idle();     chk("cur.off13", {31'd0, bus.cursor_row_en}, 32'd0);
        line(); idle(); chk("cur.off14", {31'd0, bus.cursor_row_en}, 32'd0);
        bus.reg_cr0a = 6'h0F;
        bus.reg_cr0b = 5'd14;
        pre(5'd14);
        idle();     chk("cur.inv14", {31'd0, bus.cursor_row_en}, 32'd0);
        line(); idle(); chk("cur.inv15", {31'd0, bus.cursor_row_en}, 32'd0);

        // Reset mid-row at row 7 with cursor and underline active
        bus.reg_cr0a = 6'h05;
        bus.reg_cr0b = 5'd10;
        bus.reg_cr14 = 5'd7;
        bus.reg_cr09 = 6'h1F;
        pre(5'd6);
        line(); idle();
        chk("pre_rst.row", {27'd0, bus.row_scan}, 32'd7);
        chk("pre_rst.cur", {31'd0, bus.cursor_row_en}, 32'd1);
        chk("pre_rst.ul", {31'd0, bus.underline_row}, 32'd1);
        #2 h_reset_n = 1'b0;
        #1;
        chk_row("rst_mid", 5'd0, 1'b0, 1'b0);
        chk("rst_mid.cur", {31'd0, bus.cursor_row_en}, 32'd0);
        chk("rst_mid.ul", {31'd0, bus.underline_row}, 32'd0);
        chk("rst_mid.cblink", {31'd0, bus.cursor_blink}, {31'd0, BLINK_RST});
        chk("rst_mid.chblink", {31'd0, bus.char_blink}, {31'd0, BLINK_RST});
        idle();
        h_reset_n = 1'b1;
        pre(5'd3);  chk_row("post_rst", 5'd3, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vrow_scan.md
# vrow_scan

Character-row scan-line counter for the VGA CRT path. It sits directly downstream of the vertical CRT controller and consumes its per-scanline and frame strobes: the text line-end pulse, the pre-display pulse and the split-screen pulse. From these it produces the row-scan count used for font addressing, the character-row-end strobe that advances the memory address counter, and the cursor-row and underline-row qualifiers. It also holds the frame-based blink counter for the cursor and for blinking characters.

## Interface
Parameters:
- none

Ports (clock and reset first):
- t_crt_clk  in  1  CRT clock; the only clock in the block.
- h_reset_n  in  1  Reset, asynchronous, active-low.
- txt_crt_line_end_pulse  in  1  One-cycle pulse per displayed scanline; this is the line-advance event.
- c_pre_vde  in  1  Frame start: display begins on the next scanline.
- c_split_screen_pulse  in  1  Line compare hit; screen B starts.
- c_vde  in  1  Vertical display active.
- reg_cr08  in  5  Preset row scan, CR08[4:0].
- reg_cr09  in  6  {CR09[7] double scan, CR09[4:0] max scan line}.
- reg_cr0a  in  6  {CR0A[5] cursor off, CR0A[4:0] cursor start}.
- reg_cr0b  in  5  Cursor end, CR0B[4:0].
- reg_cr14  in  5  Underline location, CR14[4:0].
- row_scan  out  5  Current scan line within the character row.
- row_end_pulse  out  1  One cycle high when the last scan of a row completes.
- dbl_phase  out  1  Double-scan phase (0 = first copy, 1 = second copy).
- cursor_row_en  out  1  Current scan lies inside the cursor band.
- underline_row  out  1  Current scan equals the underline location.
- cursor_blink  out  1  Cursor visible phase.
- char_blink  out  1  Blinking-attribute visible phase.

## Operation
- Event priority each cycle: c_pre_vde, then c_split_screen_pulse, then txt_crt_line_end_pulse.
- c_pre_vde:
  - row_scan <= reg_cr08[4:0]; dbl_phase <= 0.
  - The blink counter increments.
  - No row_end_pulse is generated.
- c_split_screen_pulse: row_scan <= 0; dbl_phase <= 0; no row_end_pulse. The preset is ignored for screen B.
- txt_crt_line_end_pulse while c_vde = 1:
  - With double scan on (CR09[7]) and dbl_phase = 0: dbl_phase <= 1 only.
  - Otherwise dbl_phase <= 0, then:
    - If row_scan == CR09[4:0]: row_scan <= 0 and row_end_pulse = 1 on the next cycle.
    - Else row_scan <= row_scan + 1, 5-bit modulo. If the preset exceeds the max scan line, the counter wraps 31 -> 0 and keeps counting until it equals the max.
- txt_crt_line_end_pulse while c_vde = 0: ignored.
- cursor_row_en is 1 only when all of these hold:
  - CR0A[5] = 0;
  - CR0A[4:0] <= row_scan;
  - row_scan <= CR0B[4:0].
  - Consequence: if start > end, there is no cursor.
- underline_row = (row_scan == CR14[4:0]).
- Blink counter: 5 bits, wraps 31 -> 0.
  - cursor_blink = cnt[3], which toggles every 8 frames.
  - char_blink = cnt[4], which toggles every 16 frames.
- Register inputs are sampled live; a change takes effect at the next event.

## Timing
- Reset values: every output and every internal register is 0.
- row_scan, dbl_phase and row_end_pulse update in the cycle after the triggering strobe.
- row_end_pulse is exactly one cycle wide.
- cursor_row_en and underline_row are registered from row_scan, so they have a 2-cycle latency from the strobe. They settle well before the next line end.
- cursor_blink and char_blink update in the cycle after c_pre_vde.
- Reset asserted mid-row: all state clears immediately. The first c_pre_vde after reset reloads the preset.

## Configuration
- Macro VROW_BLINK_EN.
- Defined: the blink counter is present and behaves as in Operation.
- Undefined: the counter is removed; cursor_blink = 1 and char_blink = 1 permanently, including during reset.

## Structure
- Shared package vga_crt_pkg holds:
  - constants ROW_W = 5 and BLINK_W = 5;
  - bit-position constants for CR09_DBL (7) and CR0A_OFF (5).
- One sub-module, vrow_blink_cntr: the frame blink counter, instantiated only under VROW_BLINK_EN.

## Test plan
- Preset and row end:
  - Stimulus: CR08 = 2, CR09 = 0x03, c_pre_vde, then 3 line pulses.
  - Required: row_scan 2, 3, 0; row_end_pulse after the 2nd pulse only.
- Double scan:
  - Stimulus: CR09 = 0x81, 4 line pulses.
  - Required: row_scan 0, 0, 1, 1, 0; dbl_phase alternates; one row_end_pulse after the 4th pulse.
- Split screen with simultaneous line pulse:
  - Stimulus: row_scan = 5, then c_split_screen_pulse and txt_crt_line_end_pulse in the same cycle.
  - Required: row_scan = 0; no row_end_pulse.
- Cursor band:
  - Stimulus: CR0A = 0x0D, CR0B = 0x0E.
  - Required: cursor_row_en high only for row_scan 13 and 14.
  - Then CR0A = 0x2D: cursor_row_en never high.
  - Then CR0A = 0x0F with CR0B = 0x0E: cursor_row_en never high.
- Blink, with VROW_BLINK_EN defined:
  - Stimulus: 8 c_pre_vde pulses, then 16 in total.
  - Required: cursor_blink rises after the 8th; char_blink rises after the 16th.
  - Without the macro, both outputs stay 1.
- Reset mid-row: assert h_reset_n low at row_scan = 7 -> every output is 0 immediately.
